nios_oci_trace_capture: RTL
===========================

// Module: nios_oci_trace_capture
// PURPOSE
//  Parametrised successor to the OCI test-bench monitor: records packed data-trace words (dct_buffer) into a circular buffer.
//  Capture uses the same dct_buffer/dct_count/test_ending/test_has_ended signals.
//  Freezes after a programmable post-trigger window and is read back oldest-first by the bench or a debug master.
//  Sits beside nios2_gen2 cpu_oci in simulation and debug builds.
// PARAMETERS
//  DATA_W     30  width of dct_buffer / stored trace word
//  CNT_W      4   width of dct_count
//  FULL_COUNT 3   dct_count value marking a completed packed word
//  DEPTH      16  buffer entries, power of two, >=2; ADDR_W = $clog2(DEPTH)
//  POST_TRIG  4   words captured after test_ending before freeze, 0..DEPTH-1
// PORTS
//  clk            in  1          system clock, all logic rising-edge
//  reset_n        in  1          asynchronous, active-low reset
//  dct_buffer     in  DATA_W     packed trace word from OCI
//  dct_count      in  CNT_W      OCI packing counter
//  test_ending    in  1          trigger: start post-trigger window
//  test_has_ended in  1          force immediate freeze
//  arm            in  1          pulse: clear buffer, begin capture
//  rd_en          in  1          read request (honoured only in DONE)
//  rd_data        out DATA_W     read word, registered
//  rd_valid       out 1          rd_data valid, one-cycle pulse
//  rd_last        out 1          with rd_valid: newest stored word
//  state          out 2          0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  fill           out ADDR_W+1   stored words, saturates at DEPTH
//  wrapped        out 1          oldest words overwritten since arm
// BEHAVIOUR
//  Reset: state=IDLE; fill=0; wrapped=0; rd_data=0; rd_valid=0; rd_last=0; pointers=0; prev_count=0.
//  Capture strobe cap: dct_count==FULL_COUNT && prev_count!=FULL_COUNT.
//   prev_count is dct_count registered every cycle in all states, so cap fires once per completed word.
//  IDLE: ignore cap. arm -> ARMED, clear wr_ptr, fill and wrapped.
//  ARMED: on cap, write dct_buffer at wr_ptr; wr_ptr++ modulo DEPTH; fill++ saturating at DEPTH.
//   A write when fill==DEPTH overwrites the oldest entry and sets wrapped (sticky until arm).
//  ARMED exits:
//   test_ending -> POST, post_cnt=POST_TRIG. If POST_TRIG==0 -> DONE directly.
//   A cap in the same cycle as test_ending is written and is not counted in post_cnt.
//  POST: each cap writes as in ARMED and decrements post_cnt; the write that takes post_cnt to 0 moves to DONE.
//  test_has_ended in ARMED or POST -> DONE next cycle. A cap in that same cycle is still written. Wins over test_ending.
//  DONE: writes blocked. rd_ptr initialised on entry to oldest entry: wrapped ? wr_ptr : 0; rd_left=fill.
//  Read: rd_en with rd_left>0 in DONE -> next cycle rd_valid=1, rd_data=mem[rd_ptr]; rd_ptr++ mod DEPTH; rd_left--.
//   rd_last=1 when rd_left was 1. Back-to-back rd_en gives one word per cycle.
//   rd_en with rd_left==0, or outside DONE: rd_valid=0, rd_data holds its last value.
//  arm in any state: restart to ARMED, clear fill/wrapped/wr_ptr. Aborts POST or readout.
//   arm has priority over test_ending and test_has_ended in the same cycle.
//  Memory is not cleared by arm or reset; only entries < fill are ever read.
//  Asserting reset_n low at any time returns all outputs to reset values asynchronously.
//  fill never exceeds DEPTH; pointers wrap silently; no overflow error flag beyond wrapped.
// TESTING
//  1 Reset mid-POST -> state=0, fill=0, wrapped=0, rd_valid=0 immediately while reset_n low.
//  2 arm, 5 words 0x1..0x5 (dct_count 0->3), test_has_ended -> state=3, fill=5; 5 reads = 1..5, rd_last on 5.
//  3 DEPTH=16, 20 words 1..20 then test_has_ended -> wrapped=1, fill=16; reads 5..20 in order.
//  4 dct_count held at 3 for 10 cycles -> exactly one word captured.
//  5 POST_TRIG=4: 3 words, test_ending, 6 more words -> fill=7, DONE after 4th post word; last read=7th word.
//  6 test_ending+cap same cycle; later arm+test_has_ended same cycle -> cap stored, not counted; arm wins, state=1, fill=0.

Source files
------------

// File: rtl/nios_oci_trace_capture.sv
// nios_oci_trace_capture
//   Records completed OCI data-trace words into a circular buffer. Capture
//   freezes after a programmable post-trigger window (or immediately on
//   test_has_ended); the frozen contents are then read back oldest-first.
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   dct_buffer, dct_count  packed trace word and its packing counter
//   test_ending            trigger: open the post-trigger window
//   test_has_ended         force an immediate freeze
//   arm                    clear the buffer and begin capture
//   rd_en                  read request, honoured only once frozen
//   rd_data/rd_valid/rd_last  registered read word, strobe, newest-word flag
//   state                  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   fill, wrapped          stored word count (saturating), overwrite flag
module nios_oci_trace_capture #(
  parameter int unsigned DATA_W     = 30,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned FULL_COUNT = 3,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned POST_TRIG  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     arm,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     wrapped
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_V  = ADDR_W'(POST_TRIG);
  localparam logic [CNT_W-1:0]  FULL_V  = CNT_W'(FULL_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  prev_count;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   fill_d;
  logic [ADDR_W:0]   rd_left;
  logic              wrapped_d;
  logic              cap, we, rd_fire, enter_done;

  assign state = state_q;

  // One strobe per completed word: only the rising transition into FULL_COUNT.
  assign cap = (dct_count == FULL_V) && (prev_count != FULL_V);
  assign we  = cap && !arm && ((state_q == ARMED) || (state_q == POST));
  assign rd_fire = (state_q == DONE) && !arm && rd_en && (rd_left != '0);

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        ARMED: begin
          if (test_has_ended)  state_d = DONE;
          else if (test_ending) state_d = (POST_TRIG == 0) ? DONE : POST;
        end
        POST: begin
          if (test_has_ended)                   state_d = DONE;
          else if (cap && post_cnt == ADDR_W'(1)) state_d = DONE;
        end
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the write-side state, so the readout pointers captured on
  // entry to DONE already include a word written in the freezing cycle.
  always_comb begin
    wr_ptr_d  = wr_ptr;
    fill_d    = fill;
    wrapped_d = wrapped;
    if (arm) begin
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
    end else if (we) begin
      wr_ptr_d = wr_ptr + 1'b1;
      if (fill == DEPTH_V) wrapped_d = 1'b1;
      else                 fill_d    = fill + 1'b1;
    end
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= dct_buffer;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      fill       <= '0;
      rd_left    <= '0;
      wrapped    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      prev_count <= dct_count;
      wr_ptr     <= wr_ptr_d;
      fill       <= fill_d;
      wrapped    <= wrapped_d;

      if (!arm && state_q == ARMED && test_ending)
        post_cnt <= POST_V;
      else if (!arm && state_q == POST && cap)
        post_cnt <= post_cnt - 1'b1;

      if (enter_done) begin
        rd_ptr  <= wrapped_d ? wr_ptr_d : '0;
        rd_left <= fill_d;
      end else if (rd_fire) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end

      rd_valid <= rd_fire;
      rd_last  <= rd_fire && (rd_left == (ADDR_W+1)'(1));
      if (rd_fire) rd_data <= mem[rd_ptr];
    end
  end

endmodule
